// File: rtl/vend_sched.sv
// Two-panel vending scheduler sharing one dispense unit, with round-robin arbitration and timeout refund.
// Optional refill input is enabled by defining VEND_REFILL_EN.
module vend_sched #(
  parameter int unsigned PRICE      = 3,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       disp_done,
`ifdef VEND_REFILL_EN
  input  logic       refill,
`endif
  output logic       disp_start,
  output logic       disp_sel,
  output logic       vend_a,
  output logic       vend_b,
  output logic [3:0] change_a,
  output logic [3:0] change_b,
  output logic       change_vld_a,
  output logic       change_vld_b,
  output logic       coin_rej_a,
  output logic       coin_rej_b,
  output logic [3:0] credit_a,
  output logic [3:0] credit_b,
  output logic [3:0] stock,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DISP, S_SETTLE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_credit_a, r_credit_b, r_stock;
  logic [CW-1:0]   r_change_a, r_change_b;
  logic [TW-1:0]   r_cnt;
  logic            r_ptr, r_sel, r_disp_start, r_fault;
  logic            r_vend_a, r_vend_b, r_change_vld_a, r_change_vld_b;
  logic            r_coin_rej_a, r_coin_rej_b;

  logic            w_elig_a, w_elig_b, w_win_b, w_grant;
  logic            w_blk_a, w_blk_b, w_timeout, w_finish;
  logic            w_rfd_a, w_rfd_b, w_clr_a, w_clr_b;
  logic [CW:0]     w_coin_a, w_coin_b;

  // Returns {reject, new_credit}; a coin is applied on top of the (possibly cleared) base credit.
  function automatic logic [CW:0] coin_upd(input logic [CW-1:0] base, input logic [1:0] code,
                                           input logic blk);
    logic [CW:0] sum;
    sum = {1'b0, base} + {3'b000, code};
    if (code == 2'b00)                                   coin_upd = {1'b0, base};
    else if (code == 2'b11 || blk || sum > 5'd15)        coin_upd = {1'b1, base};
    else                                                 coin_upd = {1'b0, sum[CW-1:0]};
  endfunction

  always_comb begin
    w_elig_a  = req_a && (r_credit_a >= CW'(PRICE)) && (r_stock != '0);
    w_elig_b  = req_b && (r_credit_b >= CW'(PRICE)) && (r_stock != '0);
    w_win_b   = w_elig_b && (!w_elig_a || r_ptr);
    w_grant   = (r_state == S_IDLE) && (w_elig_a || w_elig_b);
    w_blk_a   = ((r_state == S_GRANT) || (r_state == S_DISP)) && !r_sel;
    w_blk_b   = ((r_state == S_GRANT) || (r_state == S_DISP)) &&  r_sel;
    w_timeout = (r_state == S_DISP) && !disp_done && (r_cnt == TW'(TIMEOUT - 1));
    w_finish  = (r_state == S_SETTLE) || w_timeout;
    // Out-of-stock refund: stock of zero already rules out a grant this cycle.
    w_rfd_a   = (r_state == S_IDLE) && req_a && (r_stock == '0);
    w_rfd_b   = (r_state == S_IDLE) && req_b && (r_stock == '0);
    w_clr_a   = (w_finish && !r_sel) || w_rfd_a;
    w_clr_b   = (w_finish &&  r_sel) || w_rfd_b;
    w_coin_a  = coin_upd(w_clr_a ? '0 : r_credit_a, coin_a, w_blk_a);
    w_coin_b  = coin_upd(w_clr_b ? '0 : r_credit_b, coin_b, w_blk_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_credit_a     <= '0;
      r_credit_b     <= '0;
      r_stock        <= CW'(STOCK_INIT);
      r_change_a     <= '0;
      r_change_b     <= '0;
      r_cnt          <= '0;
      r_ptr          <= 1'b0;
      r_sel          <= 1'b0;
      r_disp_start   <= 1'b0;
      r_fault        <= 1'b0;
      r_vend_a       <= 1'b0;
      r_vend_b       <= 1'b0;
      r_change_vld_a <= 1'b0;
      r_change_vld_b <= 1'b0;
      r_coin_rej_a   <= 1'b0;
      r_coin_rej_b   <= 1'b0;
    end else begin
      r_disp_start   <= 1'b0;
      r_fault        <= 1'b0;
      r_vend_a       <= 1'b0;
      r_vend_b       <= 1'b0;
      r_change_vld_a <= 1'b0;
      r_change_vld_b <= 1'b0;
      r_change_a     <= '0;
      r_change_b     <= '0;
      r_credit_a     <= w_coin_a[CW-1:0];
      r_credit_b     <= w_coin_b[CW-1:0];
      r_coin_rej_a   <= w_coin_a[CW];
      r_coin_rej_b   <= w_coin_b[CW];

      if (w_rfd_a && (r_credit_a != '0)) begin
        r_change_vld_a <= 1'b1;
        r_change_a     <= r_credit_a;
      end
      if (w_rfd_b && (r_credit_b != '0)) begin
        r_change_vld_b <= 1'b1;
        r_change_b     <= r_credit_b;
      end

      case (r_state)
        S_IDLE: begin
`ifdef VEND_REFILL_EN
          if (refill) r_stock <= CW'(STOCK_INIT);
`endif
          if (w_grant) begin
            r_state      <= S_GRANT;
            r_disp_start <= 1'b1;
            r_sel        <= w_win_b;
          end
        end
        S_GRANT: begin
          r_state <= S_DISP;
          r_cnt   <= '0;
        end
        S_DISP: begin
          if (disp_done) begin
            r_state <= S_SETTLE;
            if (!r_sel) begin
              r_vend_a       <= 1'b1;
              r_change_vld_a <= 1'b1;
              r_change_a     <= r_credit_a - CW'(PRICE);
            end else begin
              r_vend_b       <= 1'b1;
              r_change_vld_b <= 1'b1;
              r_change_b     <= r_credit_b - CW'(PRICE);
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_fault <= 1'b1;
            if (!r_sel) begin
              r_change_vld_a <= 1'b1;
              r_change_a     <= r_credit_a;
            end else begin
              r_change_vld_b <= 1'b1;
              r_change_b     <= r_credit_b;
            end
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        S_SETTLE: begin
          r_state <= S_IDLE;
          r_ptr   <= ~r_ptr;
          if (r_stock != '0) r_stock <= r_stock - CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign disp_start   = r_disp_start;
  assign disp_sel     = r_sel;
  assign vend_a       = r_vend_a;
  assign vend_b       = r_vend_b;
  assign change_a     = r_change_a;
  assign change_b     = r_change_b;
  assign change_vld_a = r_change_vld_a;
  assign change_vld_b = r_change_vld_b;
  assign coin_rej_a   = r_coin_rej_a;
  assign coin_rej_b   = r_coin_rej_b;
  assign credit_a     = r_credit_a;
  assign credit_b     = r_credit_b;
  assign stock        = r_stock;
  assign busy         = (r_state != S_IDLE);
  assign fault        = r_fault;

endmodule

// File: tb/tb_vend_sched.sv
// Directed self-checking bench for vend_sched: vend, arbitration, coin rejection, timeout, out-of-stock, reset.
module tb_vend_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_a, coin_b;
  logic       req_a, req_b, disp_done;
`ifdef VEND_REFILL_EN
  logic       refill;
`endif
  logic       disp_start, disp_sel, vend_a, vend_b;
  logic [3:0] change_a, change_b;
  logic       change_vld_a, change_vld_b, coin_rej_a, coin_rej_b;
  logic [3:0] credit_a, credit_b, stock;
  logic       busy, fault;

  int checks   = 0;
  int failures = 0;

  vend_sched dut (
    .clk(clk), .rst(rst),
    .coin_a(coin_a), .coin_b(coin_b),
    .req_a(req_a), .req_b(req_b),
    .disp_done(disp_done),
`ifdef VEND_REFILL_EN
    .refill(refill),
`endif
    .disp_start(disp_start), .disp_sel(disp_sel),
    .vend_a(vend_a), .vend_b(vend_b),
    .change_a(change_a), .change_b(change_b),
    .change_vld_a(change_vld_a), .change_vld_b(change_vld_b),
    .coin_rej_a(coin_rej_a), .coin_rej_b(coin_rej_b),
    .credit_a(credit_a), .credit_b(credit_b),
    .stock(stock), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; coin_a = 2'b00; coin_b = 2'b00;
    req_a = 1'b0; req_b = 1'b0; disp_done = 1'b0;
`ifdef VEND_REFILL_EN
    refill = 1'b0;
`endif
    step(); step();
    check("rst_stock", 8'(stock), 8'd8);
    check("rst_credit_a", 8'(credit_a), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_start", 8'(disp_start), 8'd0);
    rst = 1'b1;
    step();

    // Basic vend on panel A with a request arriving before credit is sufficient
    coin_a = 2'b10; step();
    check("v1_credit2", 8'(credit_a), 8'd2);
    coin_a = 2'b01; req_a = 1'b1; step();
    check("v1_credit3", 8'(credit_a), 8'd3);
    check("v1_nostart_low_credit", 8'(disp_start), 8'd0);
    coin_a = 2'b00; step();
    check("v1_start", 8'(disp_start), 8'd1);
    check("v1_sel", 8'(disp_sel), 8'd0);
    req_a = 1'b0; step();
    check("v1_start_pulse", 8'(disp_start), 8'd0);
    check("v1_busy", 8'(busy), 8'd1);
    disp_done = 1'b1; step();
    check("v1_vend_a", 8'(vend_a), 8'd1);
    check("v1_chg_vld", 8'(change_vld_a), 8'd1);
    check("v1_chg", 8'(change_a), 8'd0);
    disp_done = 1'b0; step();
    check("v1_stock", 8'(stock), 8'd7);
    check("v1_credit_clr", 8'(credit_a), 8'd0);
    check("v1_idle", 8'(busy), 8'd0);

    // Credit overflow and invalid coin rejection
    for (int i = 0; i < 7; i++) begin
      coin_a = 2'b10; step();
    end
    check("ov_credit14", 8'(credit_a), 8'd14);
    coin_a = 2'b10; step();
    check("ov_rej", 8'(coin_rej_a), 8'd1);
    check("ov_hold", 8'(credit_a), 8'd14);
    coin_a = 2'b11; step();
    check("inv_rej", 8'(coin_rej_a), 8'd1);
    check("inv_hold", 8'(credit_a), 8'd14);
    coin_a = 2'b00; step();
    check("rej_clear", 8'(coin_rej_a), 8'd0);

    // Timeout: no disp_done for TIMEOUT cycles in DISP
    req_a = 1'b1; step();
    check("to_start", 8'(disp_start), 8'd1);
    req_a = 1'b0; step();
    coin_a = 2'b01; coin_b = 2'b10; step();
    check("srv_rej_a", 8'(coin_rej_a), 8'd1);
    check("srv_hold_a", 8'(credit_a), 8'd14);
    check("oth_acc_b", 8'(credit_b), 8'd2);
    check("oth_norej_b", 8'(coin_rej_b), 8'd0);
    coin_a = 2'b00; coin_b = 2'b00;
    for (int i = 0; i < 13; i++) step();
    check("to_not_yet", 8'(fault), 8'd0);
    check("to_still_busy", 8'(busy), 8'd1);
    step();
    check("to_fault", 8'(fault), 8'd1);
    check("to_refund_vld", 8'(change_vld_a), 8'd1);
    check("to_refund", 8'(change_a), 8'd14);
    check("to_stock", 8'(stock), 8'd7);
    check("to_credit_clr", 8'(credit_a), 8'd0);
    check("to_idle", 8'(busy), 8'd0);
    step();
    check("to_fault_pulse", 8'(fault), 8'd0);

    // Stray disp_done in IDLE has no effect
    disp_done = 1'b1; step();
    disp_done = 1'b0;
    check("stray_busy", 8'(busy), 8'd0);
    check("stray_vend", 8'(vend_a), 8'd0);

    // Reset in the middle of DISP
    coin_a = 2'b10; step();
    step();
    coin_a = 2'b00; req_a = 1'b1; step();
    req_a = 1'b0; step();
    step();
    check("mid_busy_pre", 8'(busy), 8'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_credit_a", 8'(credit_a), 8'd0);
    check("mid_rst_credit_b", 8'(credit_b), 8'd0);
    check("mid_rst_stock", 8'(stock), 8'd8);
    step();
    rst = 1'b1;
    step();

    // Simultaneous requests: A first, then B right after
    coin_a = 2'b10; coin_b = 2'b10; step();
    coin_a = 2'b10; coin_b = 2'b01; step();
    check("rr_credit_a", 8'(credit_a), 8'd4);
    check("rr_credit_b", 8'(credit_b), 8'd3);
    coin_a = 2'b00; coin_b = 2'b00; req_a = 1'b1; req_b = 1'b1; step();
    check("rr_start_a", 8'(disp_start), 8'd1);
    check("rr_sel_a", 8'(disp_sel), 8'd0);
    req_a = 1'b0; step();
    disp_done = 1'b1; step();
    check("rr_vend_a", 8'(vend_a), 8'd1);
    check("rr_chg_a", 8'(change_a), 8'd1);
    check("rr_no_vend_b", 8'(vend_b), 8'd0);
    disp_done = 1'b0; step();
    check("rr_idle", 8'(busy), 8'd0);
    step();
    check("rr_start_b", 8'(disp_start), 8'd1);
    check("rr_sel_b", 8'(disp_sel), 8'd1);
    req_b = 1'b0; step();
    disp_done = 1'b1; step();
    check("rr_vend_b", 8'(vend_b), 8'd1);
    check("rr_chg_b", 8'(change_b), 8'd0);
    disp_done = 1'b0; step();
    check("rr_stock", 8'(stock), 8'd6);

    // Drain remaining stock through panel A
    for (int i = 0; i < 6; i++) begin
      coin_a = 2'b10; step();
      coin_a = 2'b01; step();
      coin_a = 2'b00; req_a = 1'b1; step();
      req_a = 1'b0; step();
      disp_done = 1'b1; step();
      check("drain_vend", 8'(vend_a), 8'd1);
      disp_done = 1'b0; step();
    end
    check("drain_stock0", 8'(stock), 8'd0);

    // Out of stock: full refund, no dispense
    coin_b = 2'b10; step();
    step();
    coin_b = 2'b01; step();
    check("oos_credit_b", 8'(credit_b), 8'd5);
    coin_b = 2'b00; req_b = 1'b1; step();
    check("oos_vld", 8'(change_vld_b), 8'd1);
    check("oos_chg", 8'(change_b), 8'd5);
    check("oos_nostart", 8'(disp_start), 8'd0);
    check("oos_clr", 8'(credit_b), 8'd0);
    step();
    check("oos_zero_nostrobe", 8'(change_vld_b), 8'd0);
    check("oos_stock_nowrap", 8'(stock), 8'd0);
    req_b = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
